// File: rtl/conv3x3_mac_seq.sv
// Sequential 3x3 convolution MAC: one shared multiplier, nine taps over nine cycles, saturated fixed-point output.
// Optional build macro CONV_RELU_EN clamps negative results to zero after saturation.
module conv3x3_mac_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [9*DATA_WIDTH-1:0]        in_win,
  input  logic signed [DATA_WIDTH-1:0]   w0,
  input  logic signed [DATA_WIDTH-1:0]   w1,
  input  logic signed [DATA_WIDTH-1:0]   w2,
  input  logic signed [DATA_WIDTH-1:0]   w3,
  input  logic signed [DATA_WIDTH-1:0]   w4,
  input  logic signed [DATA_WIDTH-1:0]   w5,
  input  logic signed [DATA_WIDTH-1:0]   w6,
  input  logic signed [DATA_WIDTH-1:0]   w7,
  input  logic signed [DATA_WIDTH-1:0]   w8,
  input  logic signed [DATA_WIDTH-1:0]   bias,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [DATA_WIDTH-1:0]   out_data,
  output logic                           out_sat
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_FIN,
    S_OUT
  } state_t;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t                        state_q, state_d;
  logic [3:0]                    idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]  pix_q [9];
  logic signed [DATA_WIDTH-1:0]  pix_d [9];
  logic signed [DATA_WIDTH-1:0]  wgt_q [9];
  logic signed [DATA_WIDTH-1:0]  wgt_d [9];
  logic signed [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                          out_sat_q, out_sat_d;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic [DATA_WIDTH:0]           sat_res;
  logic                          accept;

  function automatic logic signed [ACC_WIDTH-1:0] bias_to_acc(
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [ACC_WIDTH-1:0] ext;
    ext = {{(ACC_WIDTH-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
    return ext <<< FRAC_BITS;
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] prod_to_acc(
    input logic signed [2*DATA_WIDTH-1:0] p
  );
    return {{(ACC_WIDTH-2*DATA_WIDTH){p[2*DATA_WIDTH-1]}}, p};
  endfunction

  // Returns {sat_flag, result}; the shift floors toward -inf before clamping.
  function automatic logic [DATA_WIDTH:0] saturate(
    input logic signed [ACC_WIDTH-1:0] a
  );
    logic signed [ACC_WIDTH-1:0]  sh;
    logic signed [DATA_WIDTH-1:0] r;
    logic                         s;
    sh = a >>> FRAC_BITS;
    if (sh > SAT_MAX) begin
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      s = 1'b1;
    end else if (sh < SAT_MIN) begin
      r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      s = 1'b1;
    end else begin
      r = sh[DATA_WIDTH-1:0];
      s = 1'b0;
    end
`ifdef CONV_RELU_EN
    // A negative clamp to zero is rectification, not saturation.
    if (r[DATA_WIDTH-1]) begin
      r = '0;
      s = 1'b0;
    end
`endif
    return {s, r};
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign accept    = in_valid & in_ready;
  assign prod      = pix_q[idx_q] * wgt_q[idx_q];
  assign sat_res   = saturate(acc_q);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    pix_d      = pix_q;
    wgt_d      = wgt_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          for (int i = 0; i < 9; i++) begin
            pix_d[i] = in_win[i*DATA_WIDTH +: DATA_WIDTH];
          end
          wgt_d[0] = w0;
          wgt_d[1] = w1;
          wgt_d[2] = w2;
          wgt_d[3] = w3;
          wgt_d[4] = w4;
          wgt_d[5] = w5;
          wgt_d[6] = w6;
          wgt_d[7] = w7;
          wgt_d[8] = w8;
          acc_d    = bias_to_acc(bias);
          idx_d    = 4'd0;
          state_d  = S_ACC;
        end
      end
      // One tap per cycle through the shared multiplier.
      S_ACC: begin
        acc_d = acc_q + prod_to_acc(prod);
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd8) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        out_sat_d  = sat_res[DATA_WIDTH];
        out_data_d = sat_res[DATA_WIDTH-1:0];
        state_d    = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 4'd0;
      acc_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  // Operand capture holds only data and is always written before use.
  always_ff @(posedge clk) begin
    pix_q <= pix_d;
    wgt_q <= wgt_d;
  end

endmodule

// File: tb/tb_conv3x3_mac_seq.sv
// Scoreboard bench for conv3x3_mac_seq: expectations queued at window acceptance, compared at result.
module tb_conv3x3_mac_seq;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [9*DW-1:0] in_win;
  logic [DW-1:0]   wv [9];
  logic [DW-1:0]   bias;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic            out_sat;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_data_q [$];
  logic          exp_sat_q  [$];

  always #5 clk = ~clk;

  conv3x3_mac_seq #(.DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(40)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win),
    .w0(wv[0]), .w1(wv[1]), .w2(wv[2]), .w3(wv[3]), .w4(wv[4]),
    .w5(wv[5]), .w6(wv[6]), .w7(wv[7]), .w8(wv[8]), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9*DW-1:0] rep9(input logic [DW-1:0] v);
    return {9{v}};
  endfunction

  // Integer reference: Q8.8 products summed with bias, floor shift, clamp.
  function automatic logic [DW:0] model(input logic [9*DW-1:0] p, input logic [9*DW-1:0] w,
                                        input logic [DW-1:0] b);
    longint acc;
    longint sh;
    logic [DW-1:0] r;
    logic s;
    acc = longint'($signed(b)) * 256;
    for (int i = 0; i < 9; i++) begin
      acc += longint'($signed(p[i*DW +: DW])) * longint'($signed(w[i*DW +: DW]));
    end
    sh = acc >>> 8;
    if (sh > 32767) begin
      r = 16'h7FFF; s = 1'b1;
    end else if (sh < -32768) begin
      r = 16'h8000; s = 1'b1;
    end else begin
      r = sh[15:0]; s = 1'b0;
    end
`ifdef CONV_RELU_EN
    if (r[15]) begin
      r = '0; s = 1'b0;
    end
`endif
    return {s, r};
  endfunction

  task automatic drive_window(input logic [9*DW-1:0] pix, input logic [9*DW-1:0] wts,
                              input logic [DW-1:0] b, input logic [DW-1:0] ed, input logic es);
    int n = 0;
    in_win = pix;
    for (int i = 0; i < 9; i++) wv[i] = wts[i*DW +: DW];
    bias     = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_data_q.push_back(ed);
    exp_sat_q.push_back(es);
  endtask

  task automatic wait_result(output logic [DW-1:0] d, output logic s, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    d = out_data;
    s = out_sat;
    if (out_valid && out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_win    = '0;
    bias      = '0;
    for (int i = 0; i < 9; i++) wv[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    total++; if (out_sat !== 1'b0) begin bad++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] d, ed;
    logic s, es;
    int c;
    drive_window(rep9(16'h0100), rep9(16'h0100), 16'h0080, 16'h0980, 1'b0);
    wait_result(d, s, c);
    ed = exp_data_q.pop_front();
    es = exp_sat_q.pop_front();
    total++; if (c !== 10) begin bad++; $display("FAIL basic_latency got=%0d exp=10", c); end
    total++; if (d !== ed) begin bad++; $display("FAIL basic_data got=%h exp=%h", d, ed); end
    total++; if (s !== es) begin bad++; $display("FAIL basic_sat got=%b exp=%b", s, es); end
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_post_hs got=v%b r%b exp=v0 r1", out_valid, in_ready);
    end
  endtask

  task automatic test_negative();
    logic [DW-1:0] d, ed;
    logic s, es;
    int c;
`ifdef CONV_RELU_EN
    drive_window(rep9(16'h0100), rep9(16'hFF00), 16'h0000, 16'h0000, 1'b0);
`else
    drive_window(rep9(16'h0100), rep9(16'hFF00), 16'h0000, 16'hF700, 1'b0);
`endif
    wait_result(d, s, c);
    ed = exp_data_q.pop_front();
    es = exp_sat_q.pop_front();
    total++; if ({s, d} !== {es, ed}) begin bad++; $display("FAIL negative got=%b/%h exp=%b/%h", s, d, es, ed); end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] d, ed;
    logic s, es;
    int c;
    drive_window(rep9(16'h7FFF), rep9(16'h7FFF), 16'h7FFF, 16'h7FFF, 1'b1);
    wait_result(d, s, c);
    ed = exp_data_q.pop_front();
    es = exp_sat_q.pop_front();
    total++; if ({s, d} !== {es, ed}) begin bad++; $display("FAIL sat_pos got=%b/%h exp=%b/%h", s, d, es, ed); end
`ifdef CONV_RELU_EN
    drive_window(rep9(16'h7FFF), rep9(16'h8000), 16'h0000, 16'h0000, 1'b0);
`else
    drive_window(rep9(16'h7FFF), rep9(16'h8000), 16'h0000, 16'h8000, 1'b1);
`endif
    wait_result(d, s, c);
    ed = exp_data_q.pop_front();
    es = exp_sat_q.pop_front();
    total++; if ({s, d} !== {es, ed}) begin bad++; $display("FAIL sat_neg got=%b/%h exp=%b/%h", s, d, es, ed); end
  endtask

  task automatic test_truncation();
    logic [DW-1:0] d, ed;
    logic s, es;
    int c;
`ifdef CONV_RELU_EN
    drive_window({128'h0, 16'h0001}, {128'h0, 16'hFFFF}, 16'h0000, 16'h0000, 1'b0);
`else
    drive_window({128'h0, 16'h0001}, {128'h0, 16'hFFFF}, 16'h0000, 16'hFFFF, 1'b0);
`endif
    wait_result(d, s, c);
    ed = exp_data_q.pop_front();
    es = exp_sat_q.pop_front();
    total++; if ({s, d} !== {es, ed}) begin bad++; $display("FAIL trunc_neg got=%b/%h exp=%b/%h", s, d, es, ed); end
    drive_window({128'h0, 16'h0001}, {128'h0, 16'h0001}, 16'h0000, 16'h0000, 1'b0);
    wait_result(d, s, c);
    ed = exp_data_q.pop_front();
    es = exp_sat_q.pop_front();
    total++; if ({s, d} !== {es, ed}) begin bad++; $display("FAIL trunc_pos got=%b/%h exp=%b/%h", s, d, es, ed); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d, ed;
    logic s, es;
    int c;
    out_ready = 1'b0;
    drive_window(rep9(16'h0100), rep9(16'h0100), 16'h0080, 16'h0980, 1'b0);
    ed = exp_data_q.pop_front();
    es = exp_sat_q.pop_front();
    // Scramble every input while the window is in flight and then held.
    for (int k = 1; k <= 15; k++) begin
      for (int i = 0; i < 9; i++) begin
        in_win[i*DW +: DW] = 16'($urandom);
        wv[i] = 16'($urandom);
      end
      bias     = 16'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready k=%0d got=%b exp=0", k, in_ready); end
      if (k >= 10) begin
        total++;
        if ({out_valid, out_sat, out_data} !== {1'b1, es, ed}) begin
          bad++; $display("FAIL bp_hold k=%0d got=v%b %b/%h exp=v1 %b/%h", k, out_valid, out_sat, out_data, es, ed);
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got=v%b r%b exp=v0 r1", out_valid, in_ready);
    end
`ifdef CONV_RELU_EN
    drive_window({128'h0, 16'h0001}, {128'h0, 16'hFFFF}, 16'h0000, 16'h0000, 1'b0);
`else
    drive_window({128'h0, 16'h0001}, {128'h0, 16'hFFFF}, 16'h0000, 16'hFFFF, 1'b0);
`endif
    wait_result(d, s, c);
    ed = exp_data_q.pop_front();
    es = exp_sat_q.pop_front();
    total++; if ({s, d} !== {es, ed}) begin bad++; $display("FAIL bp_next got=%b/%h exp=%b/%h", s, d, es, ed); end
  endtask

  task automatic test_back_to_back();
    logic [9*DW-1:0] p, w;
    logic [DW-1:0] b, d, ed;
    logic [DW:0] m;
    logic s, es;
    int c;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 9; i++) begin
        p[i*DW +: DW] = (n < 4) ? 16'($urandom_range(0, 1023)) - 16'd512 : 16'($urandom);
        w[i*DW +: DW] = 16'($urandom_range(0, 1023)) - 16'd512;
      end
      b = 16'($urandom);
      m = model(p, w, b);
      drive_window(p, w, b, m[DW-1:0], m[DW]);
      wait_result(d, s, c);
      ed = exp_data_q.pop_front();
      es = exp_sat_q.pop_front();
      total++; if (c !== 10) begin bad++; $display("FAIL b2b_latency n=%0d got=%0d exp=10", n, c); end
      total++; if ({s, d} !== {es, ed}) begin bad++; $display("FAIL b2b_data n=%0d got=%b/%h exp=%b/%h", n, s, d, es, ed); end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d, ed;
    logic s, es;
    int c;
    int seen = 0;
    drive_window(rep9(16'h0100), rep9(16'h0100), 16'h0080, 16'h0980, 1'b0);
    void'(exp_data_q.pop_front());
    void'(exp_sat_q.pop_front());
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_immediate got=v%b r%b exp=v0 r1", out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_stale got=%0d exp=0", seen); end
    drive_window(rep9(16'h0100), rep9(16'h0100), 16'h0080, 16'h0980, 1'b0);
    wait_result(d, s, c);
    ed = exp_data_q.pop_front();
    es = exp_sat_q.pop_front();
    total++; if ({s, d} !== {es, ed}) begin bad++; $display("FAIL rstmid_after got=%b/%h exp=%b/%h", s, d, es, ed); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_truncation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
